qbus_mst: RTL

//  Q-bus master sequencer driving the 1801VP1-013 DRAM controller (vp_013) the same way a CPU does.

---
 rtl/qbus_pkg.sv | 35 +++
 rtl/qbus_sync.sv | 33 +++
 rtl/qbus_mst.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/qbus_pkg.sv
// Shared definitions for the Q-bus master: command codes, sequencer states
// and the default bus timing constants.
package qbus_pkg;

    typedef enum logic [1:0] {
        QOP_RD   = 2'b00,
        QOP_WR   = 2'b01,
        QOP_WB   = 2'b10,
        QOP_INIT = 2'b11
    } qbus_op_e;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_SYNC,
        ST_DATA,
        ST_WAIT,
        ST_HOLD,
        ST_RELEASE,
        ST_TAIL,
        ST_INIT_PRE,
        ST_INIT,
        ST_INIT_POST
    } qbus_state_e;

    localparam int TMO_CYCLES_DEF  = 64;
    localparam int WR_HOLD_DEF     = 2;
    localparam int RD_HOLD_DEF     = 1;
    localparam int INIT_CYCLES_DEF = 16;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/qbus_sync.sv
// Two-flop synchronizer for the asynchronous bus reply; resets to inactive.
module qbus_sync (
    input  logic clk,
    input  logic rst,
    input  logic d_in,
    output logic d_out
);

    logic meta_q;
    logic meta_d;
    logic sync_q;
    logic sync_d;

    // Next values simply shift the input one stage per clock.
    always_comb begin
        meta_d = d_in;
        sync_d = meta_q;
    end

    // Both stages drop to the inactive level on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign d_out = sync_q;

endmodule

// File: rtl/qbus_mst.sv
// Q-bus master sequencer: turns single req/ack commands into CPU-style
// nSYNC/nDIN/nDOUT/nWTBT/nAD bus cycles, waits for nRPLY and reports the result.
module qbus_mst
    import qbus_pkg::*;
#(
    parameter int TMO_CYCLES  = TMO_CYCLES_DEF,
    parameter int WR_HOLD     = WR_HOLD_DEF,
    parameter int RD_HOLD     = RD_HOLD_DEF,
    parameter int INIT_CYCLES = INIT_CYCLES_DEF
) (
    input  logic        PIN_CLK,
    input  logic        PIN_RST,
    input  logic        cmd_req,
    output logic        cmd_ack,
    input  logic [1:0]  cmd_op,
    input  logic [15:0] cmd_addr,
    input  logic [15:0] cmd_data,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    output logic        rsp_err,
    output logic [15:0] PIN_nAD_OUT,
    output logic        PIN_nAD_OE,
    input  logic [15:0] PIN_nAD_IN,
    output logic        PIN_nSYNC,
    output logic        PIN_nDIN,
    output logic        PIN_nDOUT,
    output logic        PIN_nWTBT,
    input  logic        PIN_nRPLY
);

    localparam int CNT_MAX = max_int(TMO_CYCLES, INIT_CYCLES);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TMO_CYCLES - 1);
    localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LAST   = CNT_W'(RD_HOLD - 1);
    localparam logic [CNT_W-1:0] WR_LAST   = CNT_W'(WR_HOLD - 1);
    localparam logic [CNT_W-1:0] EDGE_LAST = CNT_W'(1);

    qbus_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    qbus_op_e         op_q, op_d;
    logic [15:0]      data_q, data_d;
    logic [15:0]      nad_q, nad_d;
    logic             oe_q, oe_d;
    logic             nsync_q, nsync_d;
    logic             ndin_q, ndin_d;
    logic             ndout_q, ndout_d;
    logic             nwtbt_q, nwtbt_d;
    logic             cmd_ack_q, cmd_ack_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_err_q, rsp_err_d;
    logic [15:0]      rsp_data_q, rsp_data_d;

    logic             rply_s;
    logic             is_read;
    logic [CNT_W-1:0] hold_last;
    logic             go_tail;
    logic             tail_err;

    qbus_sync u_rply_sync (
        .clk   (PIN_CLK),
        .rst   (PIN_RST),
        .d_in  (~PIN_nRPLY),
        .d_out (rply_s)
    );

    assign is_read   = (op_q == QOP_RD);
    assign hold_last = is_read ? RD_LAST : WR_LAST;

    // Sequencer next state and next registered bus/response outputs.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        data_d      = data_q;
        nad_d       = nad_q;
        oe_d        = oe_q;
        nsync_d     = nsync_q;
        ndin_d      = ndin_q;
        ndout_d     = ndout_q;
        nwtbt_d     = nwtbt_q;
        cmd_ack_d   = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_data_d  = rsp_data_q;
        go_tail     = 1'b0;
        tail_err    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_req) begin
                    cmd_ack_d = 1'b1;
                    op_d      = qbus_op_e'(cmd_op);
                    data_d    = cmd_data;
                    cnt_d     = '0;
                    if (qbus_op_e'(cmd_op) == QOP_INIT) begin
                        state_d = ST_INIT_PRE;
                    end else begin
                        state_d = ST_ADDR;
                        oe_d    = 1'b1;
                        nad_d   = ~cmd_addr;
                        nwtbt_d = (qbus_op_e'(cmd_op) == QOP_RD);
                    end
                end
            end
            ST_ADDR: begin
                state_d = ST_SYNC;
                nsync_d = 1'b0;
            end
            ST_SYNC: begin
                state_d = ST_DATA;
                if (is_read) begin
                    oe_d   = 1'b0;
                    ndin_d = 1'b0;
                end else begin
                    nad_d   = ~data_q;
                    nwtbt_d = (op_q == QOP_WR);
                end
            end
            ST_DATA: begin
                state_d = ST_WAIT;
                cnt_d   = '0;
                if (!is_read) begin
                    ndout_d = 1'b0;
                end
            end
            ST_WAIT: begin
                if (rply_s) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                    if (is_read) begin
                        rsp_data_d = ~PIN_nAD_IN;
                    end
                end else if (cnt_q == TMO_LAST) begin
                    go_tail  = 1'b1;
                    tail_err = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (cnt_q == hold_last) begin
                    state_d = ST_RELEASE;
                    cnt_d   = '0;
                    nsync_d = 1'b1;
                    ndin_d  = 1'b1;
                    ndout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RELEASE: begin
                if (!rply_s) begin
                    go_tail = 1'b1;
                end else if (cnt_q == TMO_LAST) begin
                    go_tail  = 1'b1;
                    tail_err = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_TAIL: begin
                state_d = ST_IDLE;
            end
            ST_INIT_PRE: begin
                if (cnt_q == EDGE_LAST) begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                    ndout_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_INIT: begin
                if (cnt_q == INIT_LAST) begin
                    state_d = ST_INIT_POST;
                    cnt_d   = '0;
                    ndout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_INIT_POST: begin
                if (cnt_q == EDGE_LAST) begin
                    go_tail = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (go_tail) begin
            state_d     = ST_TAIL;
            nsync_d     = 1'b1;
            ndin_d      = 1'b1;
            ndout_d     = 1'b1;
            nwtbt_d     = 1'b1;
            oe_d        = 1'b0;
            nad_d       = 16'hFFFF;
            rsp_valid_d = 1'b1;
            rsp_err_d   = tail_err;
        end
    end

    // All sequencer state and registered outputs; reset releases the bus at once.
    always_ff @(posedge PIN_CLK or posedge PIN_RST) begin
        if (PIN_RST) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            op_q        <= QOP_RD;
            data_q      <= 16'h0000;
            nad_q       <= 16'hFFFF;
            oe_q        <= 1'b0;
            nsync_q     <= 1'b1;
            ndin_q      <= 1'b1;
            ndout_q     <= 1'b1;
            nwtbt_q     <= 1'b1;
            cmd_ack_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= 16'h0000;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            data_q      <= data_d;
            nad_q       <= nad_d;
            oe_q        <= oe_d;
            nsync_q     <= nsync_d;
            ndin_q      <= ndin_d;
            ndout_q     <= ndout_d;
            nwtbt_q     <= nwtbt_d;
            cmd_ack_q   <= cmd_ack_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign cmd_ack     = cmd_ack_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_data    = rsp_data_q;
    assign PIN_nAD_OUT = nad_q;
    assign PIN_nAD_OE  = oe_q;
    assign PIN_nSYNC   = nsync_q;
    assign PIN_nDIN    = ndin_q;
    assign PIN_nDOUT   = ndout_q;
    assign PIN_nWTBT   = nwtbt_q;

endmodule
